// File: rtl/inst_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// inst_sequencer_pkg
// Shared definitions for the instruction sequencer that feeds the PE-array
// control decoder: default geometry, instruction word layout, opcode values
// and the sequencer FSM state type.
// -----------------------------------------------------------------------------
package inst_sequencer_pkg;

    // Default geometry (the top-level parameters default to these).
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_AW         = 4;
    localparam int DEF_REP_W      = 5;
    localparam int DEF_PIPE_DELAY = 6;

    // Instruction word layout: opcode sits above the repeat-count field.
    localparam int OP_W = 3;

    // Decoder opcodes. LOAD doubles as the idle/no-op value on the bus.
    typedef enum logic [OP_W-1:0] {
        OP_LOAD   = 3'b000,
        OP_ADD    = 3'b001,
        OP_SUB    = 3'b010,
        OP_MUL    = 3'b100,
        OP_MULADD = 3'b101,
        OP_MULSUB = 3'b110,
        OP_MAX    = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_e;

    // Width of the in-flight counter: enough for PIPE_DELAY outstanding
    // operations plus one bit of headroom.
    function automatic int inflight_width(input int pipe_delay);
        return $clog2(pipe_delay + 1) + 1;
    endfunction

endpackage

// File: rtl/inst_sequencer_inst_ram.sv
// -----------------------------------------------------------------------------
// inst_ram
// Program store for the sequencer: DEPTH x W distributed RAM with one
// synchronous write port and one asynchronous read port.
//
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data (combinational from raddr)
// -----------------------------------------------------------------------------
module inst_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose; resetting it would turn the
    // distributed RAM into a bank of flops and the program must survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_sequencer.sv
// -----------------------------------------------------------------------------
// inst_sequencer
// Holds a host-loaded program and issues it to the PE-array control decoder,
// one instruction per non-stalled cycle, each repeated rep+1 times. Tracks
// operations in flight through the decoder pipeline via the returned dout_v
// and pulses done once the pipeline has drained.
//
// Ports:
//   clk       in  clock
//   rst       in  synchronous active-high reset
//   wr_en     in  program write strobe (honoured only while idle)
//   wr_addr   in  program write address
//   wr_data   in  instruction word {opcode[2:0], repeat[REP_W-1:0]}
//   prog_len  in  number of instructions to run, sampled on start
//   start     in  single-cycle run request (ignored while busy)
//   stall     in  hold issue for this cycle
//   dout_v    in  completion strobe returned from the decoder
//   inst_v    out instruction valid to decoder (registered)
//   opcode    out opcode to decoder, 000 whenever inst_v is low (registered)
//   busy      out high from accepted start through the done cycle
//   done      out one-cycle completion pulse
//   err       out sticky: dout_v seen with nothing in flight
// -----------------------------------------------------------------------------
module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AW         = DEF_AW,
    parameter int REP_W      = DEF_REP_W,
    parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [OP_W+REP_W-1:0] wr_data,
    input  logic [AW:0]       prog_len,
    input  logic              start,
    input  logic              stall,
    input  logic              dout_v,
    output logic              inst_v,
    output logic [OP_W-1:0]   opcode,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int WORD_W = OP_W + REP_W;
    localparam int CNT_W  = inflight_width(PIPE_DELAY);

    state_e            state;
    logic [AW-1:0]     pc;
    logic [REP_W-1:0]  rep_cnt;
    logic [AW:0]       len;
    logic [CNT_W-1:0]  inflight;

    logic              accept_start;
    logic              issue_slot;
    logic [AW-1:0]     cur_pc;
    logic [REP_W-1:0]  cur_rep;
    logic [AW:0]       cur_len;
    logic [WORD_W-1:0] rd_word;
    logic              rep_done;
    logic              last_instr;
    logic [CNT_W-1:0]  inflight_next;

    // Writes only land while the sequencer is idle and not in its done cycle.
    inst_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (WORD_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en && (state == S_IDLE) && !busy),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (cur_pc),
        .rdata (rd_word)
    );

    // The first instruction is issued on the same edge that accepts start,
    // so while idle the issue context is taken from the start inputs
    // (PC 0, repeat 0, prog_len) rather than from the registers.
    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        accept_start = 1'b0;
        issue_slot   = 1'b0;
        cur_pc       = pc;
        cur_rep      = rep_cnt;
        cur_len      = len;

        if (state == S_IDLE) begin
            accept_start = start && !busy;
            issue_slot   = accept_start && (prog_len != '0);
            cur_pc       = '0;
            cur_rep      = '0;
            cur_len      = prog_len;
        end else if (state == S_ISSUE) begin
            issue_slot   = 1'b1;
        end
    end

    assign rep_done   = (cur_rep == rd_word[REP_W-1:0]);
    assign last_instr = ({1'b0, cur_pc} == (cur_len - (AW+1)'(1)));

    // Issue and completion in the same cycle cancel; a completion with
    // nothing in flight is an error and must not wrap the counter.
    always_comb begin
        inflight_next = inflight;
        case ({inst_v, dout_v})
            2'b10:   inflight_next = inflight + 1'b1;
            2'b01:   inflight_next = (inflight == '0) ? '0 : inflight - 1'b1;
            default: inflight_next = inflight;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; later assignments in the block override
    // earlier defaults within the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= '0;
            rep_cnt  <= '0;
            len      <= '0;
            inflight <= '0;
            inst_v   <= 1'b0;
            opcode   <= OP_LOAD;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            inflight <= inflight_next;
            if (dout_v && (inflight == '0)) begin
                err <= 1'b1;
            end

            inst_v <= 1'b0;
            opcode <= OP_LOAD;
            done   <= 1'b0;

            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (accept_start) begin
                        busy    <= 1'b1;
                        len     <= prog_len;
                        pc      <= '0;
                        rep_cnt <= '0;
                        state   <= (prog_len == '0) ? S_DRAIN : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                end
                S_DRAIN: begin
                    if (inflight_next == '0) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // A stalled slot leaves PC/repeat at their current values.
            if (issue_slot && !stall) begin
                inst_v <= 1'b1;
                opcode <= rd_word[WORD_W-1:REP_W];
                if (rep_done) begin
                    rep_cnt <= '0;
                    if (last_instr) begin
                        state <= S_DRAIN;
                    end else begin
                        pc <= cur_pc + 1'b1;
                    end
                end else begin
                    rep_cnt <= cur_rep + 1'b1;
                end
            end
        end
    end

endmodule
